eater_ram_loader: RTL and testbench

- Host-side initiator for the 8-bit computer's RAM programming interface. It drives the prog_mode / addr / data lines that the computer's RAM port consumes.
- Accepts a stream of program bytes over a valid/ready handshake. Each byte goes to the next RAM address, from 0 to DEPTH-1.
- Each write uses a setup / write-strobe / hold sequence. After the last write it releases prog_mode.
- Sits between a host byte source (test harness, UART/SPI front end) and the RAM-programming pins.

---
 rtl/eater_loader_pkg.sv | 29 ++
 rtl/eater_phase_timer.sv | 27 ++
 rtl/eater_ram_loader.sv | 113 +++++++++++
 tb/tb_eater_ram_loader.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eater_loader_pkg.sv
// Shared types and constants for the 8-bit computer RAM loader.
// States, default write timing and the byte width.
package eater_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_SETUP  = 1;
    localparam int DEF_WR     = 2;
    localparam int DEF_HOLD   = 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        SETUP,
        WRITE,
        HOLD,
        FINISH
    } ld_state_e;

    typedef logic [DEF_ADDR_W-1:0] ld_addr_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/eater_phase_timer.sv
// Loadable down-counter timing the setup, write and hold phases.
// len is the phase length minus one; expired marks the last cycle.
module eater_phase_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/eater_ram_loader.sv
// Streams program bytes into the 8-bit computer's RAM through its
// programming pins, one setup/strobe/hold sequence per address.
module eater_ram_loader
    import eater_loader_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int SETUP_CYCLES = DEF_SETUP,
    parameter int WR_CYCLES    = DEF_WR,
    parameter int HOLD_CYCLES  = DEF_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] addr,
    output logic [BYTE_W-1:0] data,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    localparam int MAX_LEN = max3(SETUP_CYCLES, WR_CYCLES, HOLD_CYCLES);
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LEN    = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LEN  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);

    ld_state_e        state;
    ld_state_e        state_n;
    logic             t_load;
    logic [CNT_W-1:0] t_len;
    logic             t_expired;
    logic             xfer;

    assign xfer = byte_valid & byte_ready;

    eater_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (t_load),
        .len    (t_len),
        .expired(t_expired)
    );

    always_comb begin
        state_n = state;
        t_load  = 1'b0;
        t_len   = '0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:      if (start) state_n = WAIT_BYTE;
                WAIT_BYTE: if (xfer) state_n = SETUP;
                SETUP:     if (t_expired) state_n = WRITE;
                WRITE:     if (t_expired) state_n = HOLD;
                HOLD: begin
                    if (t_expired) begin
                        state_n = (addr == LAST) ? FINISH : WAIT_BYTE;
                    end
                end
                FINISH:    state_n = IDLE;
                default:   state_n = IDLE;
            endcase
        end
        // Each new phase reloads the timer with its own length.
        t_load = (state_n != state);
        unique case (state_n)
            SETUP:   t_len = SETUP_LEN;
            WRITE:   t_len = WR_LEN;
            HOLD:    t_len = HOLD_LEN;
            default: t_len = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prog_mode  <= 1'b0;
            addr       <= '0;
            data       <= '0;
            wr_en      <= 1'b0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != IDLE);
            byte_ready <= (state_n == WAIT_BYTE);
            wr_en      <= (state_n == WRITE);
            done       <= (state_n == FINISH);
            prog_mode  <= state_n inside {WAIT_BYTE, SETUP, WRITE, HOLD};
            if (state_n == IDLE) begin
                addr <= '0;
            end else if (state == HOLD && state_n == WAIT_BYTE) begin
                addr <= addr + 1'b1;
            end
            if (state == WAIT_BYTE && state_n == SETUP) begin
                data <= byte_in;
            end
        end
    end

endmodule

// File: tb/tb_eater_ram_loader.sv
// Randomized bench for eater_ram_loader: default and swept timing
// instances checked against a queue-based write reference.
module tb_eater_ram_loader;

    logic clk;
    logic rst_n;

    logic       start_s[2];
    logic       abort_s[2];
    logic       bv[2];
    logic [7:0] bi[2];

    logic       a_ready, a_prog, a_wr, a_busy, a_done;
    logic [3:0] a_addr;
    logic [7:0] a_data;
    logic       b_ready, b_prog, b_wr, b_busy, b_done;
    logic [1:0] b_addr;
    logic [7:0] b_data;

    logic       m_ready[2], m_prog[2], m_wr[2], m_busy[2], m_done[2];
    logic [3:0] m_addr[2];
    logic [7:0] m_data[2];

    assign m_ready[0] = a_ready;
    assign m_prog[0]  = a_prog;
    assign m_wr[0]    = a_wr;
    assign m_busy[0]  = a_busy;
    assign m_done[0]  = a_done;
    assign m_addr[0]  = a_addr;
    assign m_data[0]  = a_data;
    assign m_ready[1] = b_ready;
    assign m_prog[1]  = b_prog;
    assign m_wr[1]    = b_wr;
    assign m_busy[1]  = b_busy;
    assign m_done[1]  = b_done;
    assign m_addr[1]  = {2'b00, b_addr};
    assign m_data[1]  = b_data;

    eater_ram_loader u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[0]),
        .abort     (abort_s[0]),
        .byte_in   (bi[0]),
        .byte_valid(bv[0]),
        .byte_ready(a_ready),
        .prog_mode (a_prog),
        .addr      (a_addr),
        .data      (a_data),
        .wr_en     (a_wr),
        .busy      (a_busy),
        .done      (a_done)
    );

    eater_ram_loader #(
        .DEPTH       (4),
        .ADDR_W      (2),
        .SETUP_CYCLES(3),
        .WR_CYCLES   (1),
        .HOLD_CYCLES (2)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s[1]),
        .abort     (abort_s[1]),
        .byte_in   (bi[1]),
        .byte_valid(bv[1]),
        .byte_ready(b_ready),
        .prog_mode (b_prog),
        .addr      (b_addr),
        .data      (b_data),
        .wr_en     (b_wr),
        .busy      (b_busy),
        .done      (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int s_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction
    function automatic int w_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction
    function automatic int h_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int d_of(input int k);
        return (k == 0) ? 16 : 4;
    endfunction

    // Reference: every accepted byte must appear as exactly one write,
    // in order, at the next address, with the configured timing.
    logic [11:0] exp_q[2][$];
    logic [7:0]  ram[2][16];
    logic [7:0]  seq[16];
    bit          mon_en[2];
    bit          span_chk[2];
    int          done_cnt[2], wr_cnt[2];
    int          stab[2], bcnt[2], wid[2], hl[2];
    bit          wok[2], pwr[2], pbusy[2], pprog[2];
    logic [3:0]  la[2], wa[2];
    logic [7:0]  ld[2], wd[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            mon_en[k] = 0; span_chk[k] = 0; done_cnt[k] = 0; wr_cnt[k] = 0;
            stab[k] = 0; bcnt[k] = 0; wid[k] = 0; hl[k] = 0; wok[k] = 1;
            pwr[k] = 0; pbusy[k] = 0; pprog[k] = 0;
            la[k] = '0; wa[k] = '0; ld[k] = '0; wd[k] = '0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [11:0] e;
            if (m_addr[k] == la[k] && m_data[k] == ld[k]) stab[k]++;
            else stab[k] = 1;
            if (m_busy[k] && !pbusy[k]) bcnt[k] = 0;
            if (m_busy[k]) bcnt[k]++;
            if (m_wr[k] && !pwr[k]) begin
                wid[k] = 0; wa[k] = m_addr[k]; wd[k] = m_data[k]; wok[k] = 1;
                wr_cnt[k]++;
                ram[k][m_addr[k]] = m_data[k];
                if (mon_en[k]) begin
                    check("setup_stable", int'(stab[k] - 1 >= s_of(k)), 1);
                    check("wr_expected", int'(exp_q[k].size() != 0), 1);
                    if (exp_q[k].size() != 0) begin
                        e = exp_q[k].pop_front();
                        check("wr_addr", int'(m_addr[k]), int'(e[11:8]));
                        check("wr_data", int'(m_data[k]), int'(e[7:0]));
                    end
                end
            end
            if (m_wr[k]) begin
                wid[k]++;
                if (m_addr[k] != wa[k] || m_data[k] != wd[k]) wok[k] = 0;
            end
            if (!m_wr[k] && pwr[k]) begin
                if (mon_en[k]) check("wr_width", wid[k], w_of(k));
                hl[k] = h_of(k);
            end
            if (hl[k] > 0 && !m_wr[k]) begin
                if (m_addr[k] != wa[k] || m_data[k] != wd[k]) wok[k] = 0;
                hl[k]--;
                if (hl[k] == 0 && mon_en[k]) check("addr_data_held", int'(wok[k]), 1);
            end
            if (m_done[k]) begin
                done_cnt[k]++;
                if (mon_en[k]) begin
                    check("prog_fall_with_done", int'({pprog[k], m_prog[k]}), 2);
                    check("done_last_addr", int'(wa[k]), d_of(k) - 1);
                    if (span_chk[k])
                        check("busy_span", bcnt[k],
                              d_of(k) * (1 + s_of(k) + w_of(k) + h_of(k)) + 1);
                end
            end
            la[k] = m_addr[k]; ld[k] = m_data[k];
            pwr[k] = m_wr[k]; pbusy[k] = m_busy[k]; pprog[k] = m_prog[k];
        end
    end

    task automatic pulse_start(input int k);
        @(negedge clk);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    task automatic run_load(input int k, input int n, input bit rnd_data,
                            input bit rnd_stall, input int stall_at,
                            input int stall_len, input int start_at,
                            input bit span);
        int  i, stalled, cyc, d0;
        bit  pulsed;
        i = 0; stalled = 0; cyc = 0; pulsed = 0;
        for (int j = 0; j < n; j++)
            seq[j] = rnd_data ? 8'($urandom) : 8'(16 + j);
        span_chk[k] = span;
        exp_q[k].delete();
        hl[k] = 0;
        wr_cnt[k] = 0;
        d0 = done_cnt[k];
        mon_en[k] = 1;
        pulse_start(k);
        while (i < n && cyc < 4000) begin
            bv[k] = 1'b1;
            bi[k] = seq[i];
            if (i == stall_at && stalled < stall_len) begin
                bv[k] = 1'b0;
                stalled++;
                if (stalled == stall_len) begin
                    check("stall_ready", int'(m_ready[k]), 1);
                    check("stall_addr", int'(m_addr[k]), stall_at);
                    check("stall_wr", int'(m_wr[k]), 0);
                end
            end else if (rnd_stall && $urandom_range(0, 2) == 0) begin
                bv[k] = 1'b0;
            end
            if (start_at >= 0 && !pulsed && int'(m_addr[k]) == start_at) begin
                start_s[k] = 1'b1;
                pulsed = 1;
            end else begin
                start_s[k] = 1'b0;
            end
            if (bv[k] && m_ready[k]) begin
                exp_q[k].push_back({4'(i), seq[i]});
                i++;
            end
            @(negedge clk);
            cyc++;
        end
        bv[k] = 1'b0;
        start_s[k] = 1'b0;
        check("bytes_taken", i, n);
        cyc = 0;
        while (done_cnt[k] == d0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check("done_once", done_cnt[k] - d0, 1);
        check("write_count", wr_cnt[k], n);
        check("queue_drained", exp_q[k].size(), 0);
        check("idle_after_load", int'(m_busy[k]), 0);
        check("prog_low_after_load", int'(m_prog[k]), 0);
        mon_en[k] = 0;
    endtask

    initial begin
        int  d0;
        bit  found, prev;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 0; abort_s[k] = 0; bv[k] = 0; bi[k] = '0;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy", int'(m_busy[k]), 0);
            check("rst_prog", int'(m_prog[k]), 0);
            check("rst_wr", int'(m_wr[k]), 0);
            check("rst_ready", int'(m_ready[k]), 0);
            check("rst_done", int'(m_done[k]), 0);
            check("rst_addr", int'(m_addr[k]), 0);
            check("rst_data", int'(m_data[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full load 0x10..0x1F with an always-valid source.
        run_load(0, 16, 0, 0, -1, 0, -1, 1);

        // Stalled source before byte 3, then the RAM image is compared.
        run_load(0, 16, 1, 0, 3, 7, -1, 0);
        for (int j = 0; j < 16; j++)
            check("ram_image", int'(ram[0][j]), int'(seq[j]));

        // Random stalls and a start pulse while busy at address 9.
        run_load(0, 16, 1, 1, -1, 0, 9, 0);

        // Abort in the middle of the write strobe at address 5.
        d0 = done_cnt[0];
        pulse_start(0);
        found = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            bv[0] = 1'b1;
            bi[0] = 8'($urandom);
            if (m_addr[0] == 4'd5 && m_wr[0]) found = 1;
            else @(negedge clk);
        end
        check("abort_reached", int'(found), 1);
        abort_s[0] = 1'b1;
        bv[0] = 1'b0;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_wr", int'(m_wr[0]), 0);
        check("abort_prog", int'(m_prog[0]), 0);
        check("abort_busy", int'(m_busy[0]), 0);
        check("abort_addr", int'(m_addr[0]), 0);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt[0] - d0, 0);
        run_load(0, 16, 1, 1, -1, 0, -1, 0);

        // Start and abort together in IDLE.
        @(negedge clk);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check("start_abort_busy", int'(m_busy[0]), 0);
        check("start_abort_prog", int'(m_prog[0]), 0);
        check("start_abort_ready", int'(m_ready[0]), 0);

        // Asynchronous reset while holding address 12.
        pulse_start(0);
        found = 0;
        prev = 0;
        for (int c = 0; c < 400 && !found; c++) begin
            bv[0] = 1'b1;
            bi[0] = 8'($urandom);
            if (m_addr[0] == 4'd12 && prev && !m_wr[0]) begin
                found = 1;
            end else begin
                prev = m_wr[0];
                @(negedge clk);
            end
        end
        check("hold12_reached", int'(found), 1);
        rst_n = 1'b0;
        bv[0] = 1'b0;
        #1;
        check("areset_prog", int'(m_prog[0]), 0);
        check("areset_addr", int'(m_addr[0]), 0);
        check("areset_data", int'(m_data[0]), 0);
        check("areset_wr", int'(m_wr[0]), 0);
        check("areset_busy", int'(m_busy[0]), 0);
        check("areset_ready", int'(m_ready[0]), 0);
        check("areset_done", int'(m_done[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_busy", int'(m_busy[0]), 0);
        check("post_reset_ready", int'(m_ready[0]), 0);
        run_load(0, 16, 1, 1, -1, 0, -1, 0);

        // Swept timing instance: DEPTH=4, SETUP=3, WR=1, HOLD=2.
        run_load(1, 4, 1, 0, -1, 0, -1, 1);
        run_load(1, 4, 1, 1, -1, 0, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
